// File: rtl/alu_mp_seq_if.sv
// Request/response handshake bundle for the multi-precision ALU sequencer.
// The master drives requests and accepts responses; the slave is the sequencer.
interface alu_mp_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_rslt;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_pari;
  logic         rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_rslt, rsp_carry, rsp_zero, rsp_pari, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_rslt, rsp_carry, rsp_zero, rsp_pari, rsp_err
  );
endinterface

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: feeds an 8-bit combinational ALU one byte per cycle, LSB first.
// Optional SUB support (op 3'b110) is enabled by defining ALU_MP_SEQ_SUB_EN.
module alu_mp_seq #(
  parameter int NBYTES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mp_seq_if.slave  bus,
  output logic [2:0]   alu_cmd,
  output logic [7:0]   alu_ina,
  output logic [7:0]   alu_inb,
  output logic         alu_sc_i,
  input  logic [7:0]   alu_rslt,
  input  logic         alu_sc_o
);
  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b111;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b101;
`ifdef ALU_MP_SEQ_SUB_EN
  localparam logic [2:0] OP_SUB = 3'b110;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q, b_q, rslt_q, rslt_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q, zero_q, pari_q, err_q;
  logic             last_byte, is_sub, add_like;

  function automatic logic op_supported(input logic [2:0] op);
    case (op)
      OP_ADD, OP_XOR, OP_AND: op_supported = 1'b1;
`ifdef ALU_MP_SEQ_SUB_EN
      OP_SUB:                 op_supported = 1'b1;
`endif
      default:                op_supported = 1'b0;
    endcase
  endfunction

`ifdef ALU_MP_SEQ_SUB_EN
  assign is_sub = (op_q == OP_SUB);
`else
  assign is_sub = 1'b0;
`endif
  assign add_like  = (op_q == OP_ADD) || is_sub;
  assign last_byte = (idx_q == LAST_IDX);

  // Full result with the byte currently on the ALU merged in, so flags see all W bits.
  always_comb begin
    rslt_d = rslt_q;
    rslt_d[{idx_q, 3'b000} +: 8] = alu_rslt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = op_supported(bus.req_op) ? RUN : DONE;
      RUN:     if (last_byte)     state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      rslt_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      pari_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          a_q     <= bus.req_a;
          b_q     <= bus.req_b;
          rslt_q  <= '0;
          idx_q   <= '0;
`ifdef ALU_MP_SEQ_SUB_EN
          carry_q <= (bus.req_op == OP_SUB);
`else
          carry_q <= 1'b0;
`endif
          // A rejected op reports a zero result, so its zero flag is already known.
          err_q   <= !op_supported(bus.req_op);
          zero_q  <= !op_supported(bus.req_op);
          pari_q  <= 1'b0;
        end
        RUN: begin
          rslt_q  <= rslt_d;
          carry_q <= add_like ? alu_sc_o : 1'b0;
          idx_q   <= last_byte ? '0 : idx_q + IDX_W'(1);
          if (last_byte) begin
            zero_q <= ~|rslt_d;
            pari_q <= ^rslt_d;
          end
        end
        DONE: if (bus.rsp_ready) begin
          rslt_q  <= '0;
          carry_q <= 1'b0;
          zero_q  <= 1'b0;
          pari_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rslt  = '0;
    bus.rsp_carry = 1'b0;
    bus.rsp_zero  = 1'b0;
    bus.rsp_pari  = 1'b0;
    bus.rsp_err   = 1'b0;
    alu_cmd       = OP_NOP;
    alu_ina       = '0;
    alu_inb       = '0;
    alu_sc_i      = 1'b0;
    case (state_q)
      IDLE: bus.req_ready = rst_n;
      RUN: begin
        alu_cmd  = is_sub ? OP_ADD : op_q;
        alu_ina  = a_q[{idx_q, 3'b000} +: 8];
        alu_inb  = is_sub ? ~b_q[{idx_q, 3'b000} +: 8] : b_q[{idx_q, 3'b000} +: 8];
        alu_sc_i = add_like ? carry_q : 1'b0;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rslt  = rslt_q;
        bus.rsp_carry = carry_q;
        bus.rsp_zero  = zero_q;
        bus.rsp_pari  = pari_q;
        bus.rsp_err   = err_q;
      end
      default: ;
    endcase
  end
endmodule
